dmem_responder: RTL and testbench

Data-memory responder for the core's data-side memory port: accepts load, store and cache-maintenance requests issued by the load/store unit and returns in-order responses with tag, read data and fault status. It holds a word-organised, byte-writable RAM window, applies configurable wait states, and signals bus and protection faults. It sits between the LSU's memory port and the top-level memory map; it also serves as the bench memory model for LSU verification.

---
 rtl/dmem_responder_pkg.sv | 55 +++++
 rtl/dmem_resp_fifo.sv | 72 +++++++
 rtl/dmem_responder.sv | 166 ++++++++++++++++
 tb/tb_dmem_responder.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: response entry layout,
// request classification and window-size helpers.
package dmem_responder_pkg;

  localparam int TAG_W  = 11;
  localparam int DATA_W = 32;

  // One queued response, packed MSB-first as {tag, data, error, load_fault, store_fault}.
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic              error;
    logic              load_fault;
    logic              store_fault;
  } resp_entry_t;

  localparam int RESP_W = $bits(resp_entry_t);

  // Field offsets inside the packed entry, for anyone slicing the raw vector.
  localparam int RESP_STORE_FAULT_BIT = 0;
  localparam int RESP_LOAD_FAULT_BIT  = 1;
  localparam int RESP_ERROR_BIT       = 2;
  localparam int RESP_DATA_LSB        = 3;
  localparam int RESP_TAG_LSB         = RESP_DATA_LSB + DATA_W;

  // Request class after priority resolution.
  typedef enum logic [2:0] {
    REQ_NONE,
    REQ_LOAD,
    REQ_STORE,
    REQ_FLUSH,
    REQ_WRITEBACK,
    REQ_INVALIDATE
  } req_kind_t;

  // Number of 32-bit words in a window of 2^addr_w bytes.
  function automatic int mem_words(input int addr_w);
    return 1 << (addr_w - 2);
  endfunction

  // Priority: load > store > flush > writeback > invalidate.
  function automatic req_kind_t decode_req(input logic       rd,
                                           input logic [3:0] wr,
                                           input logic       flush,
                                           input logic       writeback,
                                           input logic       invalidate);
    if (rd)              return REQ_LOAD;
    else if (|wr)        return REQ_STORE;
    else if (flush)      return REQ_FLUSH;
    else if (writeback)  return REQ_WRITEBACK;
    else if (invalidate) return REQ_INVALIDATE;
    else                 return REQ_NONE;
  endfunction

endpackage

// File: rtl/dmem_resp_fifo.sv
// Small synchronous FIFO holding accepted-but-unacknowledged responses.
// Pointers and occupancy reset asynchronously; storage is not reset.
module dmem_resp_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             valid_o,
  output logic             accept_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign valid_o  = (count_q != '0);
  assign accept_o = (count_q != FULL_CNT);
  assign count_o  = count_q;
  assign head_o   = mem_q[rd_ptr_q];

  // Next pointer and occupancy; no bypass, a full FIFO refuses a push even while popping.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    do_push  = push_i && accept_o;
    do_pop   = pop_i && valid_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state: pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage written at the push slot.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays carry no reset; validity comes from the reset count, and a reset array would not map to RAM.
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised byte-writable RAM window with range
// and read-only protection, in-order response queue and fixed wait states.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter logic [31:0] MEM_BASE    = 32'h8000_0000,
  parameter int          MEM_ADDR_W  = 14,
  parameter int          RO_WORDS    = 0,
  parameter int          WAIT_CYCLES = 0,
  parameter int          RESP_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_wr_i,
  input  logic        mem_rd_i,
  input  logic [3:0]  mem_wr_i,
  input  logic        mem_cacheable_i,
  input  logic [10:0] mem_req_tag_i,
  input  logic        mem_invalidate_i,
  input  logic        mem_writeback_i,
  input  logic        mem_flush_i,
  input  logic        inject_stall_i,
  output logic        mem_accept_o,
  output logic        mem_ack_o,
  output logic [31:0] mem_data_rd_o,
  output logic        mem_error_o,
  output logic [10:0] mem_resp_tag_o,
  output logic        mem_load_fault_o,
  output logic        mem_store_fault_o
);

  localparam int          MEM_WORDS = mem_words(MEM_ADDR_W);
  localparam int          IDX_W     = MEM_ADDR_W - 2;
  localparam int          CNT_W     = $clog2(RESP_DEPTH + 1);
  localparam logic [32:0] WIN_LO    = {1'b0, MEM_BASE};
  localparam logic [32:0] WIN_HI    = WIN_LO + (33'd1 << MEM_ADDR_W) - 33'd1;
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

  req_kind_t          req_kind;
  logic               req_accepted;
  logic [IDX_W-1:0]   word_idx;
  logic               in_range;
  logic               ro_hit;
  logic               store_write;
  logic [31:0]        rd_word;
  resp_entry_t        push_entry;
  resp_entry_t        head;
  logic [RESP_W-1:0]  head_bits;
  logic               head_valid;
  logic               fifo_accept;
  logic [CNT_W-1:0]   fifo_count;
  logic               new_head;
  logic [3:0]         wait_q, wait_d;
  logic [31:0]        mem_q [MEM_WORDS];

  // Byte offset and cacheability do not influence this memory's behaviour.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, mem_cacheable_i, mem_addr_i[1:0]};

  // ---------------------------------------------------------------------------
  // Request decode and acceptance
  // ---------------------------------------------------------------------------
  assign req_kind = decode_req(mem_rd_i, mem_wr_i, mem_flush_i,
                               mem_writeback_i, mem_invalidate_i);

  // Accept depends only on stall and free queue space, never on request presence.
  assign mem_accept_o = !inject_stall_i && fifo_accept;
  assign req_accepted = (req_kind != REQ_NONE) && mem_accept_o;

  assign word_idx = mem_addr_i[MEM_ADDR_W-1:2];
  assign in_range = ({1'b0, mem_addr_i} >= WIN_LO) && ({1'b0, mem_addr_i} <= WIN_HI);
  assign rd_word  = mem_q[word_idx];

  generate
    if (RO_WORDS > 0) begin : g_ro
      assign ro_hit = 32'(word_idx) < 32'(RO_WORDS);
    end else begin : g_no_ro
      assign ro_hit = 1'b0;
    end
  endgenerate

  assign store_write = req_accepted && (req_kind == REQ_STORE) && in_range && !ro_hit;

  // ---------------------------------------------------------------------------
  // RAM window
  // ---------------------------------------------------------------------------
  // Byte-lane store at the accept edge; a load on the next edge sees the new data.
  always_ff @(posedge clk) begin
    if (store_write) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wr_i[b]) mem_q[word_idx][8*b +: 8] <= mem_data_wr_i[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response entry construction
  // ---------------------------------------------------------------------------
  // Build the response for the request being accepted; maintenance ops answer clean.
  always_comb begin
    push_entry     = '0;
    push_entry.tag = mem_req_tag_i;
    case (req_kind)
      REQ_LOAD: begin
        if (in_range) push_entry.data  = rd_word;
        else          push_entry.error = 1'b1;
      end
      REQ_STORE: begin
        if (!in_range) begin
          push_entry.error = 1'b1;
        end else if (ro_hit) begin
          push_entry.error       = 1'b1;
          push_entry.store_fault = 1'b1;
        end
      end
      default: ;
    endcase
  end

  dmem_resp_fifo #(
    .WIDTH (RESP_W),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (req_accepted),
    .push_data_i (push_entry),
    .pop_i       (mem_ack_o),
    .head_o      (head_bits),
    .valid_o     (head_valid),
    .accept_o    (fifo_accept),
    .count_o     (fifo_count)
  );

  assign head = head_bits;

  // ---------------------------------------------------------------------------
  // Head wait counter
  // ---------------------------------------------------------------------------
  // Reload whenever a different entry reaches the head, otherwise count down to zero.
  always_comb begin
    if (mem_ack_o) new_head = (fifo_count > CNT_W'(1)) || req_accepted;
    else           new_head = req_accepted && !head_valid;
    wait_d = wait_q;
    if (new_head)            wait_d = WAIT_LOAD;
    else if (wait_q != 4'd0) wait_d = wait_q - 4'd1;
  end

  // Wait counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wait_q <= 4'd0;
    else     wait_q <= wait_d;
  end

  // ---------------------------------------------------------------------------
  // Response outputs, zero whenever no ack is presented
  // ---------------------------------------------------------------------------
  assign mem_ack_o         = head_valid && (wait_q == 4'd0);
  assign mem_data_rd_o     = mem_ack_o ? head.data        : 32'd0;
  assign mem_error_o       = mem_ack_o ? head.error       : 1'b0;
  assign mem_resp_tag_o    = mem_ack_o ? head.tag         : 11'd0;
  assign mem_load_fault_o  = mem_ack_o ? head.load_fault  : 1'b0;
  assign mem_store_fault_o = mem_ack_o ? head.store_fault : 1'b0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder. Two instances share clock and reset:
// index 0 has WAIT_CYCLES=0, RO_WORDS=4; index 1 has WAIT_CYCLES=3, RO_WORDS=0.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] addr_i  [2];
  logic [31:0] wdata_i [2];
  logic        rd_i    [2];
  logic [3:0]  wr_i    [2];
  logic        cach_i  [2];
  logic [10:0] tag_i   [2];
  logic        inv_i   [2];
  logic        wb_i    [2];
  logic        fl_i    [2];
  logic        stall_i [2];

  logic        accept_o [2];
  logic        ack_o    [2];
  logic [31:0] rdata_o  [2];
  logic        err_o    [2];
  logic [10:0] rtag_o   [2];
  logic        lf_o     [2];
  logic        sf_o     [2];

  dmem_responder #(
    .MEM_BASE (32'h8000_0000), .MEM_ADDR_W (14), .RO_WORDS (4),
    .WAIT_CYCLES (0), .RESP_DEPTH (2)
  ) dut0 (
    .clk (clk), .rst (rst),
    .mem_addr_i (addr_i[0]), .mem_data_wr_i (wdata_i[0]), .mem_rd_i (rd_i[0]),
    .mem_wr_i (wr_i[0]), .mem_cacheable_i (cach_i[0]), .mem_req_tag_i (tag_i[0]),
    .mem_invalidate_i (inv_i[0]), .mem_writeback_i (wb_i[0]), .mem_flush_i (fl_i[0]),
    .inject_stall_i (stall_i[0]), .mem_accept_o (accept_o[0]), .mem_ack_o (ack_o[0]),
    .mem_data_rd_o (rdata_o[0]), .mem_error_o (err_o[0]), .mem_resp_tag_o (rtag_o[0]),
    .mem_load_fault_o (lf_o[0]), .mem_store_fault_o (sf_o[0])
  );

  dmem_responder #(
    .MEM_BASE (32'h8000_0000), .MEM_ADDR_W (14), .RO_WORDS (0),
    .WAIT_CYCLES (3), .RESP_DEPTH (2)
  ) dut1 (
    .clk (clk), .rst (rst),
    .mem_addr_i (addr_i[1]), .mem_data_wr_i (wdata_i[1]), .mem_rd_i (rd_i[1]),
    .mem_wr_i (wr_i[1]), .mem_cacheable_i (cach_i[1]), .mem_req_tag_i (tag_i[1]),
    .mem_invalidate_i (inv_i[1]), .mem_writeback_i (wb_i[1]), .mem_flush_i (fl_i[1]),
    .inject_stall_i (stall_i[1]), .mem_accept_o (accept_o[1]), .mem_ack_o (ack_o[1]),
    .mem_data_rd_o (rdata_o[1]), .mem_error_o (err_o[1]), .mem_resp_tag_o (rtag_o[1]),
    .mem_load_fault_o (lf_o[1]), .mem_store_fault_o (sf_o[1])
  );

  // kind: 0 idle, 1 load, 2 store, 3 flush, 4 writeback, 5 invalidate,
  //       6 load+store, 7 store+flush
  task automatic drive_req(input int d, input int kind, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] be, input logic [10:0] t);
    addr_i[d]  = a;
    wdata_i[d] = wd;
    tag_i[d]   = t;
    cach_i[d]  = kind[0];
    rd_i[d]    = (kind == 1) || (kind == 6);
    wr_i[d]    = ((kind == 2) || (kind == 6) || (kind == 7)) ? be : 4'h0;
    fl_i[d]    = (kind == 3) || (kind == 7);
    wb_i[d]    = (kind == 4);
    inv_i[d]   = (kind == 5);
  endtask

  // Present one request until accepted, then collect its response (bounded waits).
  // got stays 0 if either bound expires; lat counts cycles after the accept cycle.
  task automatic do_req(input int d, input int kind, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be, input logic [10:0] t,
                        output logic got, output logic [10:0] rt, output logic [31:0] rdat,
                        output logic e, output logic lf, output logic sf, output int lat);
    logic acc;
    acc = 1'b0; got = 1'b0; rt = '0; rdat = '0; e = 1'b0; lf = 1'b0; sf = 1'b0; lat = -1;
    @(posedge clk); #1;
    drive_req(d, kind, a, wd, be, t);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (accept_o[d]) begin acc = 1'b1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    drive_req(d, 0, 32'd0, 32'd0, 4'h0, 11'd0);
    if (acc) begin
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (ack_o[d]) begin
          got = 1'b1; rt = rtag_o[d]; rdat = rdata_o[d];
          e = err_o[d]; lf = lf_o[d]; sf = sf_o[d]; lat = i;
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({accept_o[d], ack_o[d], err_o[d], lf_o[d], sf_o[d], rtag_o[d], rdata_o[d]} !== {1'b1, 4'b0, 11'd0, 32'd0}) begin
        errors++;
        $display("FAIL reset_outputs d%0d: got acc=%b ack=%b err=%b lf=%b sf=%b tag=%h data=%h, want acc=1 rest 0",
                 d, accept_o[d], ack_o[d], err_o[d], lf_o[d], sf_o[d], rtag_o[d], rdata_o[d]);
      end
      stall_i[d] = 1'b1;
      #1;
      checks++;
      if (accept_o[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_stall_accept d%0d: got %b want 0", d, accept_o[d]);
      end
      stall_i[d] = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    @(posedge clk); #1;
    drive_req(0, 2, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 11'd5);
    @(negedge clk);
    checks++;
    if ({accept_o[0], ack_o[0]} !== 2'b10) begin
      errors++;
      $display("FAIL basic_store_accept: got acc=%b ack=%b want acc=1 ack=0", accept_o[0], ack_o[0]);
    end
    @(posedge clk); #1;
    drive_req(0, 1, 32'h8000_0010, 32'd0, 4'h0, 11'd6);
    @(negedge clk);
    checks++;
    if ({accept_o[0], ack_o[0], err_o[0], rtag_o[0], rdata_o[0]} !== {3'b110, 11'd5, 32'd0}) begin
      errors++;
      $display("FAIL basic_store_ack: got acc=%b ack=%b err=%b tag=%0d data=%h want acc=1 ack=1 err=0 tag=5 data=0",
               accept_o[0], ack_o[0], err_o[0], rtag_o[0], rdata_o[0]);
    end
    @(posedge clk); #1;
    drive_req(0, 0, 32'd0, 32'd0, 4'h0, 11'd0);
    @(negedge clk);
    checks++;
    if ({ack_o[0], err_o[0], lf_o[0], sf_o[0], rtag_o[0], rdata_o[0]} !== {4'b1000, 11'd6, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL basic_load_ack: got ack=%b err=%b tag=%0d data=%h want ack=1 err=0 tag=6 data=deadbeef",
               ack_o[0], err_o[0], rtag_o[0], rdata_o[0]);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({ack_o[0], rtag_o[0], rdata_o[0]} !== {1'b0, 11'd0, 32'd0}) begin
      errors++;
      $display("FAIL basic_idle_after: got ack=%b tag=%0d data=%h want all 0", ack_o[0], rtag_o[0], rdata_o[0]);
    end
  endtask

  task automatic test_byte_lanes();
    logic got, e, lf, sf; logic [10:0] rt; logic [31:0] rdat; int lat;
    do_req(0, 2, 32'h8000_0020, 32'h1122_3344, 4'hF, 11'd7, got, rt, rdat, e, lf, sf, lat);
    checks++;
    if ({got, rt, e} !== {1'b1, 11'd7, 1'b0}) begin
      errors++; $display("FAIL lanes_init_store: got ack=%b tag=%0d err=%b want 1/7/0", got, rt, e);
    end
    do_req(0, 2, 32'h8000_0020, 32'h00AA_0000, 4'b0100, 11'd8, got, rt, rdat, e, lf, sf, lat);
    checks++;
    if ({got, e, rdat} !== {2'b10, 32'd0}) begin
      errors++; $display("FAIL lanes_byte_store: got ack=%b err=%b data=%h want 1/0/0", got, e, rdat);
    end
    do_req(0, 1, 32'h8000_0020, 32'd0, 4'h0, 11'd9, got, rt, rdat, e, lf, sf, lat);
    checks++;
    if ({got, rt, rdat, e, lat} !== {1'b1, 11'd9, 32'h11AA_3344, 1'b0, 32'd0}) begin
      errors++; $display("FAIL lanes_readback: got ack=%b tag=%0d data=%h err=%b lat=%0d want 1/9/11aa3344/0/0",
                         got, rt, rdat, e, lat);
    end
  endtask

  task automatic test_cmo_priority();
    logic got, e, lf, sf; logic [10:0] rt; logic [31:0] rdat; int lat;
    do_req(0, 3, 32'h0000_0000, 32'd0, 4'h0, 11'h7FF, got, rt, rdat, e, lf, sf, lat);
    checks++;
    if ({got, rt, rdat, e, lf, sf} !== {1'b1, 11'h7FF, 32'd0, 3'b000}) begin
      errors++; $display("FAIL cmo_flush: got ack=%b tag=%h data=%h err=%b want 1/7ff/0/0", got, rt, rdat, e);
    end
    do_req(0, 4, 32'h8000_0010, 32'd0, 4'h0, 11'h012, got, rt, rdat, e, lf, sf, lat);
    checks++;
    if ({got, rt, rdat, e} !== {1'b1, 11'h012, 32'd0, 1'b0}) begin
      errors++; $display("FAIL cmo_writeback: got ack=%b tag=%h data=%h err=%b want 1/012/0/0", got, rt, rdat, e);
    end
    do_req(0, 5, 32'hFFFF_FFF0, 32'd0, 4'h0, 11'h013, got, rt, rdat, e, lf, sf, lat);
    checks++;
    if ({got, rt, rdat, e} !== {1'b1, 11'h013, 32'd0, 1'b0}) begin
      errors++; $display("FAIL cmo_invalidate: got ack=%b tag=%h data=%h err=%b want 1/013/0/0", got, rt, rdat, e);
    end
    // Load beats store in the same request: old data returned, nothing written.
    do_req(0, 6, 32'h8000_0010, 32'hFFFF_FFFF, 4'hF, 11'h014, got, rt, rdat, e, lf, sf, lat);
    checks++;
    if ({got, rdat, e} !== {1'b1, 32'hDEAD_BEEF, 1'b0}) begin
      errors++; $display("FAIL prio_load_over_store: got ack=%b data=%h err=%b want 1/deadbeef/0", got, rdat, e);
    end
    do_req(0, 1, 32'h8000_0010, 32'd0, 4'h0, 11'h015, got, rt, rdat, e, lf, sf, lat);
    checks++;
    if ({got, rdat} !== {1'b1, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL prio_no_write: got ack=%b data=%h want 1/deadbeef", got, rdat);
    end
    // Store beats flush: out-of-range address makes it a bus fault.
    do_req(0, 7, 32'h0000_0100, 32'h1234_5678, 4'hF, 11'h016, got, rt, rdat, e, lf, sf, lat);
    checks++;
    if ({got, e, lf, sf} !== 4'b1100) begin
      errors++; $display("FAIL prio_store_over_flush: got ack=%b err=%b lf=%b sf=%b want 1/1/0/0", got, e, lf, sf);
    end
  endtask

  task automatic test_readonly();
    logic got, e, lf, sf; logic [10:0] rt; logic [31:0] rdat, orig; int lat;
    do_req(0, 1, 32'h8000_0008, 32'd0, 4'h0, 11'h020, got, rt, orig, e, lf, sf, lat);
    checks++;
    if ({got, e} !== 2'b10) begin
      errors++; $display("FAIL ro_load: got ack=%b err=%b want 1/0", got, e);
    end
    do_req(0, 2, 32'h8000_0008, 32'h5A5A_5A5A, 4'hF, 11'h021, got, rt, rdat, e, lf, sf, lat);
    checks++;
    if ({got, e, lf, sf, rdat} !== {4'b1101, 32'd0}) begin
      errors++; $display("FAIL ro_store_fault: got ack=%b err=%b lf=%b sf=%b data=%h want 1/1/0/1/0", got, e, lf, sf, rdat);
    end
    do_req(0, 1, 32'h8000_0008, 32'd0, 4'h0, 11'h022, got, rt, rdat, e, lf, sf, lat);
    checks++;
    if ({got, e, rdat} !== {2'b10, orig}) begin
      errors++; $display("FAIL ro_unchanged: got ack=%b err=%b data=%h want 1/0/%h", got, e, rdat, orig);
    end
    do_req(0, 2, 32'h8000_000C, 32'h0000_00FF, 4'h1, 11'h023, got, rt, rdat, e, lf, sf, lat);
    checks++;
    if ({got, e, lf, sf} !== 4'b1101) begin
      errors++; $display("FAIL ro_last_word: got ack=%b err=%b lf=%b sf=%b want 1/1/0/1", got, e, lf, sf);
    end
  endtask

  task automatic test_range();
    logic got, e, lf, sf; logic [10:0] rt; logic [31:0] rdat; int lat;
    do_req(1, 2, 32'h8000_0000, 32'h0BAD_CAFE, 4'hF, 11'd1, got, rt, rdat, e, lf, sf, lat);
    checks++;
    if ({got, rt, e, lat} !== {1'b1, 11'd1, 1'b0, 32'd3}) begin
      errors++; $display("FAIL range_store_base: got ack=%b tag=%0d err=%b lat=%0d want 1/1/0/3", got, rt, e, lat);
    end
    do_req(1, 2, 32'h8000_3FFC, 32'hCAFE_F00D, 4'hF, 11'd2, got, rt, rdat, e, lf, sf, lat);
    checks++;
    if ({got, e} !== 2'b10) begin
      errors++; $display("FAIL range_store_top: got ack=%b err=%b want 1/0", got, e);
    end
    do_req(1, 1, 32'h7FFF_FFFC, 32'd0, 4'h0, 11'd3, got, rt, rdat, e, lf, sf, lat);
    checks++;
    if ({got, e, lf, sf, rdat} !== {4'b1100, 32'd0}) begin
      errors++; $display("FAIL range_load_below: got ack=%b err=%b lf=%b sf=%b data=%h want 1/1/0/0/0", got, e, lf, sf, rdat);
    end
    do_req(1, 2, 32'h8000_4000, 32'h1234_5678, 4'hF, 11'd4, got, rt, rdat, e, lf, sf, lat);
    checks++;
    if ({got, e, lf, sf, rdat} !== {4'b1100, 32'd0}) begin
      errors++; $display("FAIL range_store_above: got ack=%b err=%b lf=%b sf=%b data=%h want 1/1/0/0/0", got, e, lf, sf, rdat);
    end
    do_req(1, 1, 32'h8000_0000, 32'd0, 4'h0, 11'd5, got, rt, rdat, e, lf, sf, lat);
    checks++;
    if ({got, e, rdat} !== {2'b10, 32'h0BAD_CAFE}) begin
      errors++; $display("FAIL range_no_alias_write: got ack=%b err=%b data=%h want 1/0/0badcafe", got, e, rdat);
    end
    do_req(1, 1, 32'h8000_3FFC, 32'd0, 4'h0, 11'd6, got, rt, rdat, e, lf, sf, lat);
    checks++;
    if ({got, e, rdat} !== {2'b10, 32'hCAFE_F00D}) begin
      errors++; $display("FAIL range_top_word: got ack=%b err=%b data=%h want 1/0/cafef00d", got, e, rdat);
    end
  endtask

  task automatic test_back_to_back();
    logic got, e, lf, sf; logic [10:0] rt; logic [31:0] rdat; int lat;
    logic [31:0] words [3];
    logic [13:0] acc_v;
    int idx, n;
    int          ack_cyc  [3];
    logic [10:0] ack_tag  [3];
    logic [31:0] ack_data [3];
    words[0] = 32'hA1A1_A1A1; words[1] = 32'hB2B2_B2B2; words[2] = 32'hC3C3_C3C3;
    for (int k = 0; k < 3; k++) begin
      do_req(1, 2, 32'h8000_0100 + 32'(4 * k), words[k], 4'hF, 11'(16 + k), got, rt, rdat, e, lf, sf, lat);
      checks++;
      if ({got, e} !== 2'b10) begin
        errors++; $display("FAIL b2b_prefill_%0d: got ack=%b err=%b want 1/0", k, got, e);
      end
    end
    idx = 0; n = 0; acc_v = '0;
    for (int k = 0; k < 3; k++) begin ack_cyc[k] = -1; ack_tag[k] = '0; ack_data[k] = '0; end
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      if (idx < 3) drive_req(1, 1, 32'h8000_0100 + 32'(4 * idx), 32'd0, 4'h0, 11'(idx + 1));
      else         drive_req(1, 0, 32'd0, 32'd0, 4'h0, 11'd0);
      @(negedge clk);
      acc_v[c] = accept_o[1];
      if (ack_o[1] && n < 3) begin
        ack_cyc[n] = c; ack_tag[n] = rtag_o[1]; ack_data[n] = rdata_o[1]; n++;
      end
      if (accept_o[1] && idx < 3) idx++;
    end
    @(posedge clk); #1;
    drive_req(1, 0, 32'd0, 32'd0, 4'h0, 11'd0);
    checks++;
    if (acc_v !== 14'b11111000100011) begin
      errors++; $display("FAIL b2b_accept_pattern: got %b want 11111000100011", acc_v);
    end
    checks++;
    if (n !== 3) begin
      errors++; $display("FAIL b2b_ack_count: got %0d want 3", n);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({ack_cyc[k], ack_tag[k], ack_data[k]} !== {32'(4 + 4 * k), 11'(k + 1), words[k]}) begin
        errors++; $display("FAIL b2b_ack_%0d: got cycle=%0d tag=%0d data=%h want cycle=%0d tag=%0d data=%h",
                           k, ack_cyc[k], ack_tag[k], ack_data[k], 4 + 4 * k, k + 1, words[k]);
      end
    end
  endtask

  task automatic test_stall_reset();
    int acc_seen, ack_seen, lat;
    logic got; logic [10:0] rt; logic [31:0] rdat;
    acc_seen = 0; ack_seen = 0;
    stall_i[1] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      drive_req(1, 1, 32'h8000_0100, 32'd0, 4'h0, 11'h030);
      @(negedge clk);
      if (accept_o[1]) acc_seen++;
      if (ack_o[1]) ack_seen++;
    end
    checks++;
    if ({acc_seen, ack_seen} !== {32'd0, 32'd0}) begin
      errors++; $display("FAIL stall_blocks_accept: got accepts=%0d acks=%0d want 0/0", acc_seen, ack_seen);
    end
    @(posedge clk); #1;
    stall_i[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (accept_o[1] !== 1'b1) begin
      errors++; $display("FAIL stall_release_accept: got %b want 1", accept_o[1]);
    end
    @(posedge clk); #1;
    drive_req(1, 0, 32'd0, 32'd0, 4'h0, 11'd0);
    got = 1'b0; rt = '0; rdat = '0; lat = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack_o[1]) begin got = 1'b1; rt = rtag_o[1]; rdat = rdata_o[1]; lat = i; break; end
    end
    checks++;
    if ({got, rt, rdat, lat} !== {1'b1, 11'h030, 32'hA1A1_A1A1, 32'd3}) begin
      errors++; $display("FAIL stall_resp: got ack=%b tag=%h data=%h lat=%0d want 1/030/a1a1a1a1/3", got, rt, rdat, lat);
    end
    // Two loads in flight, then an asynchronous reset mid-cycle.
    acc_seen = 0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      drive_req(1, 1, 32'h8000_0104, 32'd0, 4'h0, 11'(32'h031 + c));
      @(negedge clk);
      if (accept_o[1]) acc_seen++;
    end
    @(posedge clk); #1;
    drive_req(1, 0, 32'd0, 32'd0, 4'h0, 11'd0);
    checks++;
    if (acc_seen !== 2) begin
      errors++; $display("FAIL reset_prefill_accepts: got %0d want 2", acc_seen);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({accept_o[1], ack_o[1], err_o[1], lf_o[1], sf_o[1], rtag_o[1], rdata_o[1]} !== {1'b1, 4'b0, 11'd0, 32'd0}) begin
      errors++; $display("FAIL midreset_outputs: got acc=%b ack=%b err=%b tag=%h data=%h want acc=1 rest 0",
                         accept_o[1], ack_o[1], err_o[1], rtag_o[1], rdata_o[1]);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ack_seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (ack_o[1]) ack_seen++;
    end
    checks++;
    if ({ack_seen, accept_o[1], rtag_o[1], rdata_o[1]} !== {32'd0, 1'b1, 11'd0, 32'd0}) begin
      errors++; $display("FAIL postreset_no_ack: got acks=%0d acc=%b tag=%h data=%h want 0/1/0/0",
                         ack_seen, accept_o[1], rtag_o[1], rdata_o[1]);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      drive_req(d, 0, 32'd0, 32'd0, 4'h0, 11'd0);
      stall_i[d] = 1'b0;
    end
    test_reset();
    test_basic();
    test_byte_lanes();
    test_cmo_priority();
    test_readonly();
    test_range();
    test_back_to_back();
    test_stall_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
